// File: rtl/vga_pkg.sv
// Shared definitions for the VGA write-side blocks: screen defaults, FSM encoding
// and the VRAM read/write polarity.
package vga_pkg;
    localparam int H_RES_DEFAULT = 320;
    localparam int V_RES_DEFAULT = 200;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/vga_rect_clip.sv
// Clips a rectangle against the screen: exclusive end coordinates plus an empty flag.
// Purely combinational so the game logic can reuse it for collision bounds.
module vga_rect_clip
    import vga_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT,
    parameter int V_RES = V_RES_DEFAULT
) (
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic [8:0] w,
    input  logic [7:0] h,
    output logic [9:0] x_end,
    output logic [9:0] y_end,
    output logic       empty
);
    localparam logic [9:0] X_LIM = 10'(H_RES);
    localparam logic [9:0] Y_LIM = 10'(V_RES);

    logic [9:0] x_sum;
    logic [9:0] y_sum;

    assign x_sum = {1'b0, x} + {1'b0, w};
    assign y_sum = {2'b0, y} + {2'b0, h};
    assign x_end = (x_sum > X_LIM) ? X_LIM : x_sum;
    assign y_end = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    assign empty = (w == 9'd0) || (h == 8'd0) ||
                   ({1'b0, x} >= X_LIM) || ({2'b0, y} >= Y_LIM);
endmodule

// File: rtl/vga_rect_writer.sv
// Filled-rectangle VRAM writer: turns draw commands into single-pixel write cycles,
// issued only while the scan counter reports blanking.
module vga_rect_writer
    import vga_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT,
    parameter int V_RES = V_RES_DEFAULT,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [8:0]    cmd_x,
    input  logic [7:0]    cmd_y,
    input  logic [8:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic [DW-1:0] cmd_color,
    input  logic          display,
    output logic          busy,
    output logic          done,
    output logic          cs,
    output logic          rw,
    output logic          oe,
    output logic [15:0]   Address_bus,
    inout  wire  [DW-1:0] Data_bus
);
    localparam logic [15:0] PITCH = 16'(H_RES);

    state_t        state_reg;
    logic [8:0]    x_reg;
    logic [7:0]    y_reg;
    logic [8:0]    w_reg;
    logic [7:0]    h_reg;
    logic [DW-1:0] color_reg;
    logic [9:0]    cx_reg;
    logic [9:0]    cy_reg;
    logic [15:0]   row_base_reg;
    logic          last_reg;
    logic          cs_reg;
    logic          rw_reg;
    logic          data_en_reg;
    logic [15:0]   addr_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [9:0]  x_end;
    logic [9:0]  y_end;
    logic        empty;
    logic [9:0]  src_cx;
    logic [9:0]  src_cy;
    logic [15:0] src_base;
    logic [9:0]  cx_inc;
    logic [9:0]  cx_next;
    logic [9:0]  cy_next;
    logic [15:0] base_next;
    logic        last_pix;

    vga_rect_clip #(.H_RES(H_RES), .V_RES(V_RES)) u_clip (
        .x(x_reg), .y(y_reg), .w(w_reg), .h(h_reg),
        .x_end(x_end), .y_end(y_end), .empty(empty)
    );

    // SETUP issues the first pixel straight from the latched fields so the first
    // write lands one cycle after SETUP; the only multiply is the row base here.
    always_comb begin
        src_cx   = cx_reg;
        src_cy   = cy_reg;
        src_base = row_base_reg;
        if (state_reg == SETUP) begin
            src_cx   = {1'b0, x_reg};
            src_cy   = {2'b0, y_reg};
            src_base = {8'd0, y_reg} * PITCH;
        end
        cx_inc    = src_cx + 10'd1;
        cx_next   = cx_inc;
        cy_next   = src_cy;
        base_next = src_base;
        last_pix  = 1'b0;
        if (cx_inc >= x_end) begin
            cx_next   = {1'b0, x_reg};
            cy_next   = src_cy + 10'd1;
            base_next = src_base + PITCH;
            last_pix  = ((src_cy + 10'd1) == y_end);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cs_reg      <= 1'b0;
            rw_reg      <= RW_READ;
            data_en_reg <= 1'b0;
            addr_reg    <= 16'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            last_reg    <= 1'b0;
        end else begin
            cs_reg      <= 1'b0;
            rw_reg      <= RW_READ;
            data_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        x_reg     <= cmd_x;
                        y_reg     <= cmd_y;
                        w_reg     <= cmd_w;
                        h_reg     <= cmd_h;
                        color_reg <= cmd_color;
                        last_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= SETUP;
                    end
                end
                SETUP, WRITE: begin
                    if ((state_reg == SETUP && empty) || (state_reg == WRITE && last_reg)) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= WRITE;
                        if (!display) begin
                            cs_reg       <= 1'b1;
                            rw_reg       <= RW_WRITE;
                            data_en_reg  <= 1'b1;
                            addr_reg     <= src_base + {6'd0, src_cx};
                            cx_reg       <= cx_next;
                            cy_reg       <= cy_next;
                            row_base_reg <= base_next;
                            last_reg     <= last_pix;
                        end else begin
                            cx_reg       <= src_cx;
                            cy_reg       <= src_cy;
                            row_base_reg <= src_base;
                        end
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_reg == IDLE) && !rst;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign cs          = cs_reg;
    assign rw          = rw_reg;
    assign oe          = 1'b0;
    assign Address_bus = addr_reg;
    assign Data_bus    = data_en_reg ? color_reg : {DW{1'bz}};
endmodule

// File: tb/tb_vga_rect_writer.sv
// Directed bench for vga_rect_writer: logs every write cycle and done pulse relative
// to the accept edge and compares them with hand-computed sequences.
module tb_vga_rect_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [8:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic [8:0] cmd_w = '0;
    logic [7:0] cmd_h = '0;
    logic [7:0] cmd_color = '0;
    logic       display = 1'b0;
    wire        cmd_ready, busy, done, cs, rw, oe;
    wire [15:0] Address_bus;
    wire [7:0]  Data_bus;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;
    int z_bad = 0;
    int oob = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_rel[$];
    int done_q[$];
    int exp_a[$];
    int exp_d[$];
    int exp_r[$];

    always #5 clk = ~clk;

    vga_rect_writer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .display(display), .busy(busy), .done(done),
        .cs(cs), .rw(rw), .oe(oe), .Address_bus(Address_bus), .Data_bus(Data_bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cs && !rw) begin
            wr_addr.push_back(int'(Address_bus));
            wr_data.push_back(int'(Data_bus));
            wr_rel.push_back(cyc - acc + 1);
            if (Address_bus >= 16'd64000) oob++;
        end else if (Data_bus !== 8'hzz) begin
            z_bad++;
        end
        if (done) done_q.push_back(cyc - acc + 1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_rel.delete(); done_q.delete();
        exp_a.delete(); exp_d.delete(); exp_r.delete();
        z_bad = 0; oob = 0;
    endtask

    task automatic send(input int x, input int y, input int w, input int h, input int c);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 8'(c);
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        check("accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
        $display("cmd x=%0d y=%0d w=%0d h=%0d color=%02h accepted at cycle %0d", x, y, w, h, c, acc);
    endtask

    task automatic wait_done(input int n, input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (done_q.size() >= n) begin ok = 1; break; end
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < wr_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(exp_a[i]));
                check($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp_d[i]));
                check($sformatf("%s_cyc%0d", tag, i), 32'(wr_rel[i]), 32'(exp_r[i]));
            end
        end
        check({tag, "_bus_z"}, 32'(z_bad), 32'd0);
        check({tag, "_oob"}, 32'(oob), 32'd0);
    endtask

    initial begin
        int n_at;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_cs", 32'(cs), 32'd0);
        check("rst_rw", 32'(rw), 32'd1);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_addr", 32'(Address_bus), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bus_z", 32'(Data_bus === 8'hzz), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // basic rectangle
        clear_log();
        exp_a = '{1610, 1611, 1612, 1930, 1931, 1932};
        exp_d = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        exp_r = '{2, 3, 4, 5, 6, 7};
        send(10, 5, 3, 2, 8'hAA);
        wait_done(1, 30);
        compare_log("basic");
        check("basic_done_cyc", 32'(done_q[0]), 32'd8);
        @(negedge clk);
        check("basic_ready_after", 32'(cmd_ready), 32'd1);
        check("basic_busy_after", 32'(busy), 32'd0);

        // stall: display high during cycles N+3..N+6
        clear_log();
        exp_a = '{1610, 1611, 1612, 1930, 1931, 1932};
        exp_d = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        exp_r = '{2, 3, 8, 9, 10, 11};
        send(10, 5, 3, 2, 8'hAA);
        @(posedge clk); #1;
        @(posedge clk); #1 display = 1'b1;
        repeat (4) @(posedge clk);
        #1 display = 1'b0;
        wait_done(1, 30);
        compare_log("stall");
        check("stall_done_cyc", 32'(done_q[0]), 32'd12);

        // clipping at the bottom-right corner
        clear_log();
        exp_a = '{63998, 63999};
        exp_d = '{8'h3C, 8'h3C};
        exp_r = '{2, 3};
        send(318, 199, 5, 4, 8'h3C);
        wait_done(1, 30);
        compare_log("clip");
        check("clip_done_cyc", 32'(done_q[0]), 32'd4);

        // empty commands
        clear_log();
        send(10, 5, 0, 2, 8'h11);
        wait_done(1, 30);
        compare_log("empty_w");
        check("empty_w_done_cyc", 32'(done_q[0]), 32'd2);
        @(negedge clk);
        check("empty_w_ready", 32'(cmd_ready), 32'd1);
        clear_log();
        send(320, 5, 4, 2, 8'h11);
        wait_done(1, 30);
        compare_log("empty_x");
        check("empty_x_done_cyc", 32'(done_q[0]), 32'd2);
        @(negedge clk);
        check("empty_x_ready", 32'(cmd_ready), 32'd1);

        // back-to-back with fields changed while busy
        clear_log();
        exp_a = '{321, 322, 690};
        exp_d = '{8'h11, 8'h11, 8'h22};
        exp_r = '{2, 3, 7};
        @(posedge clk); #1;
        cmd_x = 9'd1; cmd_y = 8'd1; cmd_w = 9'd2; cmd_h = 8'd1; cmd_color = 8'h11;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("b2b_ready_a", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        cmd_x = 9'd50; cmd_y = 8'd2; cmd_w = 9'd1; cmd_h = 8'd1; cmd_color = 8'h22;
        $display("cmd A x=1 y=1 w=2 h=1 color=11 accepted at cycle %0d, B queued", acc);
        wait_done(1, 30);
        check("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        $display("cmd B x=50 y=2 w=1 h=1 color=22 accepted");
        wait_done(2, 30);
        repeat (4) @(negedge clk);
        compare_log("b2b");
        check("b2b_ndone", 32'(done_q.size()), 32'd2);
        check("b2b_done_a", 32'(done_q[0]), 32'd4);
        check("b2b_done_b", 32'(done_q[1]), 32'd8);

        // reset in the middle of a full-screen clear
        clear_log();
        send(0, 0, 320, 200, 8'h55);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk); #1;
                if (wr_addr.size() >= 100) begin ok = 1; break; end
            end
            check("fill_100_timeout", 32'(ok), 32'd1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("midrst_cs", 32'(cs), 32'd0);
        check("midrst_rw", 32'(rw), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        n_at = wr_addr.size();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 32'(cmd_ready), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check("midrst_no_writes", 32'(wr_addr.size()), 32'(n_at));
        check("midrst_bus_z", 32'(z_bad), 32'd0);
        $display("reset after %0d writes", n_at);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_rect_writer.md
# vga_rect_writer

Write-side engine for the video RAM: accepts filled-rectangle draw commands (ball, paddles, background clears) and turns them into single-pixel VRAM write cycles. It only writes while the scan counter reports blanking (`display` low), so it never contends with the scan-out read path (counter → address calculator → vram). It sits between the game logic, which issues commands, and the VRAM chip-select/read-write/address/data pins.

## Interface
Parameters:
- `H_RES`, 320, pixels per line; row pitch of VRAM.
- `V_RES`, 200, lines per frame; `H_RES*V_RES` ≤ 65536.
- `DW`, 8, pixel/data width.

Ports:
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: block accepts a command. Equals (state==IDLE) & ~`rst`.
- `cmd_x` in 9, `cmd_y` in 8: top-left pixel.
- `cmd_w` in 9, `cmd_h` in 8: width and height in pixels.
- `cmd_color` in `DW`: fill value.
- `display` in 1: from `vga_counter`. 1 = active video, so VRAM belongs to the reader.
- `busy` out 1: high in SETUP, WRITE and DONE.
- `done` out 1: one-cycle pulse when a command completes.
- `cs` out 1: VRAM chip select, active-high.
- `rw` out 1: 1 = read, 0 = write.
- `oe` out 1: VRAM output enable. Held 0 by this block.
- `Address_bus` out 16: pixel address.
- `Data_bus` inout `DW`: driven with the colour only in a write cycle. High-Z otherwise.

## Operation
- States: IDLE, SETUP, WRITE, DONE.
- **IDLE:** on `cmd_valid`&`cmd_ready`, latch all `cmd_*` fields, then go to SETUP.
- **SETUP** (one cycle):
  - Compute in 10 bits `x_end = min(x+w, H_RES)` and `y_end = min(y+h, V_RES)`.
  - The command is empty if `w==0`, `h==0`, `x>=H_RES` or `y>=V_RES`. An empty command goes to DONE with no writes.
  - Otherwise load `cx=x`, `cy=y`, `row_base = y*H_RES` (16 bits), then go to WRITE.
- **WRITE:**
  - Cycle with `display`=0: `cs`=1, `rw`=0, `Address_bus = row_base+cx`, `Data_bus = color`.
    - If `cx+1 < x_end`: `cx++`.
    - Else: `cx=x`, `cy++`, `row_base += H_RES`.
    - Once `cy+1 == y_end` and the row is finished, go to DONE.
  - Cycle with `display`=1 (stall): `cs`=0, `rw`=1, `Data_bus` high-Z. Counters hold and no pixel is lost.
- **DONE:** `done`=1 for one cycle, then IDLE. `cmd_ready` is 0 in this cycle.
- Order of writes: row-major, left to right, top to bottom. Each clipped pixel is written exactly once. Nothing outside the screen is ever addressed.
- Commands presented while `cmd_ready`=0 are ignored. The source must hold them until they are accepted.
- **Reset mid-operation:** state goes to IDLE on the same edge, and no further write cycle is issued.

## Timing
- All outputs are registered except `cmd_ready` and the `Data_bus` tri-state enable. The enable is (`cs` & ~`rw`) and is registered together with `cs`.
- Reset values:
  - `cs`=0, `rw`=1, `oe`=0, `Address_bus`=0, `Data_bus` high-Z.
  - `busy`=0, `done`=0, `cmd_ready`=0 during `rst`.
  - `cmd_ready`=1 on the first cycle after `rst` falls.
- **Latency:** command accepted at edge N. SETUP occupies cycle N+1. The earliest write cycle is N+2.
  - With no stalls there are exactly `w_eff*h_eff` consecutive write cycles.
  - `done` is high in the cycle after the last write.
  - An empty command raises `done` at cycle N+2.
- **Throughput:** one pixel per unstalled cycle. The next command can be accepted in the cycle after `done`.
- `display` is sampled on every WRITE edge. A 0→1 transition stalls starting with the next write slot. Stalls may span whole active lines.

## Structure
- Shared package `vga_pkg`:
  - `H_RES`, `V_RES` defaults.
  - State encoding localparams (IDLE=0, SETUP=1, WRITE=2, DONE=3).
  - `RW_READ`=1, `RW_WRITE`=0.
- Sub-module `vga_rect_clip` (combinational): takes x/y/w/h and returns `x_end`, `y_end` and `empty`. It is reusable by the game logic for collision bounds.
- The address multiply happens only in SETUP as `y*H_RES`. Per row it is incremental (`+H_RES`), so there is no per-pixel multiplier.

## Test plan
- **Basic rectangle:** x=10, y=5, w=3, h=2, colour 0xAA, `display`=0.
  - Writes at addresses 1610, 1611, 1612, 1930, 1931, 1932, all with data 0xAA.
  - `done` at cycle N+8.
- **Stall:** same command, `display`=1 for cycles N+3..N+6.
  - Write sequence is identical and `cs`=0 during the stall.
  - `done` is delayed by 4 cycles. The bus is high-Z while stalled.
- **Clipping:** x=318, y=199, w=5, h=4.
  - Exactly 2 writes, at 63998 and 63999.
  - No address ≥ 64000.
- **Empty commands:** w=0, then x=320.
  - No `cs` assertion.
  - `done` at N+2.
  - `cmd_ready` returns in the following cycle.
- **Reset mid-fill:** full-screen clear (0, 0, 320, 200), `rst` pulsed after 100 writes.
  - The cycle after the reset edge shows `cs`=0, `rw`=1, `busy`=0.
  - `cmd_ready`=1 once `rst` falls.
- **Back-to-back handshake:** `cmd_valid` held high with two commands queued.
  - Second command is accepted only in the IDLE cycle after `done`.
  - Fields changed while busy are not latched.
